alu_cmd_ctrl: RTL and testbench
===============================

Name: alu_cmd_ctrl

Overview:
- Command front-end and result back-end for the registered ALU stage.
- Accepts a byte stream from the UART RX parallel interface and assembles command frames from it.
- For each complete frame, loads operands and function, fires the ALU for exactly one cycle and captures the registered result.
- Serialises the result LSB-first as bytes to the UART TX parallel interface under a busy handshake.

Parameters:
- DATA_WIDTH, 8, byte width of RX/TX data and ALU operands.
- OUT_WIDTH, 16, ALU result width; must be a non-zero multiple of DATA_WIDTH.
- CMD_FULL, 8'hCC, command byte: frame is CMD, A, B, FUN.
- CMD_FUN_ONLY, 8'hDD, command byte: frame is CMD, FUN; reuses the stored A and B.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid this cycle.
- ALU_OUT  in  OUT_WIDTH  registered ALU result.
- ALU_OUT_VLD  in  1  ALU result valid, one cycle after ALU_EN.
- TX_BUSY  in  1  TX cannot accept a byte while high.
- ALU_A  out  DATA_WIDTH  operand A register.
- ALU_B  out  DATA_WIDTH  operand B register.
- ALU_FUN  out  4  function register.
- ALU_EN  out  1  single-cycle ALU enable.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  TX_P_DATA valid; held until accepted.
- FRAME_ERR  out  1  one-cycle pulse on a bad command byte or a dropped RX byte.

Behaviour:
- Reset (RST low, asynchronous): all outputs 0, FSM to IDLE, result register 0, byte counter 0. Reset mid-frame or mid-send abandons that transaction; no partial TX byte is issued after reset release.
- FSM states: IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_RES, SEND.
- IDLE, on RX_D_VLD:
  - Data == CMD_FULL -> GET_A.
  - Data == CMD_FUN_ONLY -> GET_FUN.
  - Any other value -> FRAME_ERR pulses next cycle; stay in IDLE.
- GET_A, on RX_D_VLD: ALU_A <= data; -> GET_B.
- GET_B, on RX_D_VLD: ALU_B <= data; -> GET_FUN.
- GET_FUN, on RX_D_VLD: ALU_FUN <= data[3:0] (upper bits ignored); -> EXEC.
- No timeout in the GET states: wait indefinitely for the next byte.
- EXEC: ALU_EN = 1 for exactly one cycle; -> WAIT_RES. ALU_A, ALU_B and ALU_FUN are stable from the cycle ALU_EN rises until the next frame writes them.
- WAIT_RES: on ALU_OUT_VLD, capture ALU_OUT into the result register, clear the byte counter; -> SEND. Nominal latency EXEC->WAIT_RES capture is 1 cycle; the FSM still waits if ALU_OUT_VLD is delayed.
- SEND:
  - TX_P_DATA = result[cnt*DATA_WIDTH +: DATA_WIDTH]; TX_D_VLD = 1.
  - A byte is accepted on any cycle with TX_D_VLD = 1 and TX_BUSY = 0; on acceptance cnt increments and TX_D_VLD drops for one cycle before the next byte is presented.
  - After byte OUT_WIDTH/DATA_WIDTH - 1 is accepted -> IDLE; TX_D_VLD = 0.
  - TX_BUSY held high indefinitely stalls SEND with data and valid stable.
- RX bytes arriving in EXEC, WAIT_RES or SEND are dropped, each causing one FRAME_ERR pulse. There is no buffering.
- ALU_A and ALU_B persist across frames; CMD_FUN_ONLY with no prior CMD_FULL uses the reset value 0.
- Throughput: CMD_FULL frame to first TX_D_VLD is 3 cycles after the FUN byte strobe (EXEC, WAIT_RES, SEND).
- FRAME_ERR is registered: it pulses one cycle after the offending strobe.

Decomposition:
- Shared package holds:
  - the state enumeration;
  - CMD_FULL / CMD_FUN_ONLY constants;
  - ALU function codes: ADD 0, SUB 1, MUL 2, DIV 3, AND 4, OR 5, NAND 6, NOR 7, XOR 8, XNOR 9, CMP_EQ A, CMP_GT B, CMP_LT C, SHR D, SHL E. Testbenches use these same codes.
- Natural sub-module: alu_result_serializer. It covers the SEND state, counter and TX handshake, and is started by a load strobe with the result word. The frame FSM stays in the top level.

Test Plan:
- CC,05,03,00 with TX_BUSY = 0: ALU_EN is one pulse with A=05, B=03, FUN=0; the ALU returns 0008; TX bytes are 08 then 00; FSM returns to IDLE.
- CC,10,20,02 with TX_BUSY held high for 10 cycles: TX_D_VLD and TX_P_DATA=00 stay stable and are accepted on TX_BUSY fall; result 0200 is sent as 00 then 02.
- DD,01 after the previous frame: A=10, B=20 are reused with FUN=1; result FFF0 is sent as F0, FF.
- Byte 5A in IDLE: FRAME_ERR pulses once, nothing is issued, and a following CC frame executes normally.
- An RX byte injected during SEND: FRAME_ERR pulses and the TX sequence is unchanged.
- RST low after CC,07 (mid GET_B) and released: all outputs 0 and ALU_A back to 0; a new DD,00 frame sends 00,00.

Source files
------------

// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared types and constants for the ALU command front-end and result serializer.
package alu_cmd_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned OUT_WIDTH_DEF  = 16;
  localparam int unsigned FUN_WIDTH      = 4;

  localparam logic [7:0] CMD_FULL_DEF     = 8'hCC;
  localparam logic [7:0] CMD_FUN_ONLY_DEF = 8'hDD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_EXEC,
    ST_WAIT_RES,
    ST_SEND
  } ctrl_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_VALID,
    SER_GAP
  } ser_state_e;

  typedef enum logic [3:0] {
    FUN_ADD    = 4'h0,
    FUN_SUB    = 4'h1,
    FUN_MUL    = 4'h2,
    FUN_DIV    = 4'h3,
    FUN_AND    = 4'h4,
    FUN_OR     = 4'h5,
    FUN_NAND   = 4'h6,
    FUN_NOR    = 4'h7,
    FUN_XOR    = 4'h8,
    FUN_XNOR   = 4'h9,
    FUN_CMP_EQ = 4'hA,
    FUN_CMP_GT = 4'hB,
    FUN_CMP_LT = 4'hC,
    FUN_SHR    = 4'hD,
    FUN_SHL    = 4'hE
  } alu_fun_e;

  // Counter width that stays legal for a single-byte result.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// RX, ALU and TX signal bundle between the command controller and its neighbours.
interface alu_cmd_ctrl_if
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF
) ();

  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic [OUT_WIDTH-1:0]  ALU_OUT;
  logic                  ALU_OUT_VLD;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] ALU_A;
  logic [DATA_WIDTH-1:0] ALU_B;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  ALU_EN;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  FRAME_ERR;

  // Controller side.
  modport master (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR
  );

  // UART/ALU environment side.
  modport slave (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR
  );

endinterface

// File: rtl/alu_result_serializer.sv
// Holds the ALU result and sends it LSB-byte-first over the TX valid/busy handshake.
module alu_result_serializer
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [OUT_WIDTH-1:0]  result_word,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_vld,
  output logic                  done_c
);

  localparam int unsigned NUM_BYTES = OUT_WIDTH / DATA_WIDTH;
  localparam int unsigned CNT_W     = cnt_width(NUM_BYTES);

  ser_state_e           st_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [OUT_WIDTH-1:0] word_q;
  logic                 accept_c;
  logic                 last_c;

  assign accept_c = (st_q == SER_VALID) && !tx_busy;
  assign last_c   = (cnt_q == CNT_W'(NUM_BYTES - 1));
  assign done_c   = accept_c && last_c;

  // word_q shifts down one byte per accepted byte so the next byte is always at the bottom.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q    <= SER_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      tx_data <= '0;
      tx_vld  <= 1'b0;
    end else if (load) begin
      st_q    <= SER_VALID;
      cnt_q   <= '0;
      word_q  <= result_word;
      tx_data <= result_word[DATA_WIDTH-1:0];
      tx_vld  <= 1'b1;
    end else begin
      case (st_q)
        SER_VALID: begin
          if (!tx_busy) begin
            tx_vld <= 1'b0;
            cnt_q  <= cnt_q + CNT_W'(1);
            word_q <= word_q >> DATA_WIDTH;
            st_q   <= last_c ? SER_IDLE : SER_GAP;
          end
        end
        SER_GAP: begin
          tx_data <= word_q[DATA_WIDTH-1:0];
          tx_vld  <= 1'b1;
          st_q    <= SER_VALID;
        end
        default: begin
          tx_vld <= 1'b0;
          st_q   <= SER_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Frame FSM: assembles RX command frames, fires the ALU once and hands the result to the serializer.
module alu_cmd_ctrl
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned           OUT_WIDTH    = OUT_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] CMD_FULL     = DATA_WIDTH'(CMD_FULL_DEF),
  parameter logic [DATA_WIDTH-1:0] CMD_FUN_ONLY = DATA_WIDTH'(CMD_FUN_ONLY_DEF)
) (
  input  logic          CLK,
  input  logic          RST,
  alu_cmd_ctrl_if.master bus
);

  ctrl_state_e           state_q;
  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic [FUN_WIDTH-1:0]  alu_fun_q;
  logic                  alu_en_q;
  logic                  frame_err_q;
  logic                  load_c;
  logic                  ser_done_c;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_vld;

  assign load_c = (state_q == ST_WAIT_RES) && bus.ALU_OUT_VLD;

  // Operands persist across frames; only the frame bytes that carry them overwrite them.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      alu_en_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      alu_en_q    <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.RX_D_VLD) begin
            if (bus.RX_P_DATA == CMD_FULL)          state_q <= ST_GET_A;
            else if (bus.RX_P_DATA == CMD_FUN_ONLY) state_q <= ST_GET_FUN;
            else                                     frame_err_q <= 1'b1;
          end
        end
        ST_GET_A: begin
          if (bus.RX_D_VLD) begin
            alu_a_q <= bus.RX_P_DATA;
            state_q <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (bus.RX_D_VLD) begin
            alu_b_q <= bus.RX_P_DATA;
            state_q <= ST_GET_FUN;
          end
        end
        ST_GET_FUN: begin
          if (bus.RX_D_VLD) begin
            alu_fun_q <= bus.RX_P_DATA[FUN_WIDTH-1:0];
            alu_en_q  <= 1'b1;
            state_q   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          frame_err_q <= bus.RX_D_VLD;
          state_q     <= ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          frame_err_q <= bus.RX_D_VLD;
          if (bus.ALU_OUT_VLD) state_q <= ST_SEND;
        end
        ST_SEND: begin
          frame_err_q <= bus.RX_D_VLD;
          if (ser_done_c) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  alu_result_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_ser (
    .CLK         (CLK),
    .RST         (RST),
    .load        (load_c),
    .result_word (bus.ALU_OUT),
    .tx_busy     (bus.TX_BUSY),
    .tx_data     (tx_data),
    .tx_vld      (tx_vld),
    .done_c      (ser_done_c)
  );

  assign bus.ALU_A     = alu_a_q;
  assign bus.ALU_B     = alu_b_q;
  assign bus.ALU_FUN   = alu_fun_q;
  assign bus.ALU_EN    = alu_en_q;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.TX_P_DATA = tx_data;
  assign bus.TX_D_VLD  = tx_vld;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a behavioural registered ALU and a TX byte monitor.
module tb_alu_cmd_ctrl;
  import alu_cmd_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_cmd_ctrl_if #(.DATA_WIDTH(8), .OUT_WIDTH(16)) bus_if ();

  alu_cmd_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int alu_en_cnt = 0;
  int alu_delay = 0;
  int cd = 0;
  logic pend = 1'b0;
  logic [7:0] txq[$];
  int e0;
  logic stable;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      FUN_ADD:    return 16'(a) + 16'(b);
      FUN_SUB:    return 16'(a) - 16'(b);
      FUN_MUL:    return 16'(a) * 16'(b);
      FUN_DIV:    return (b != 8'd0) ? 16'(a / b) : 16'd0;
      FUN_AND:    return 16'(a & b);
      FUN_OR:     return 16'(a | b);
      FUN_NAND:   return 16'(~(a & b));
      FUN_NOR:    return 16'(~(a | b));
      FUN_XOR:    return 16'(a ^ b);
      FUN_XNOR:   return 16'(~(a ^ b));
      FUN_CMP_EQ: return 16'(a == b);
      FUN_CMP_GT: return 16'(a > b);
      FUN_CMP_LT: return 16'(a < b);
      FUN_SHR:    return 16'(a >> 1);
      FUN_SHL:    return 16'(a) << 1;
      default:    return 16'd0;
    endcase
  endfunction

  // Registered ALU; result valid alu_delay cycles later than the nominal one-cycle latency.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus_if.ALU_OUT     <= 16'd0;
      bus_if.ALU_OUT_VLD <= 1'b0;
      pend               <= 1'b0;
      cd                 <= 0;
    end else begin
      bus_if.ALU_OUT_VLD <= 1'b0;
      if (bus_if.ALU_EN) begin
        alu_en_cnt     <= alu_en_cnt + 1;
        bus_if.ALU_OUT <= alu_f(bus_if.ALU_A, bus_if.ALU_B, bus_if.ALU_FUN);
        if (alu_delay == 0) bus_if.ALU_OUT_VLD <= 1'b1;
        else begin
          pend <= 1'b1;
          cd   <= alu_delay;
        end
      end else if (pend) begin
        if (cd == 1) begin
          bus_if.ALU_OUT_VLD <= 1'b1;
          pend               <= 1'b0;
        end
        cd <= cd - 1;
      end
    end
  end

  always @(posedge CLK) begin
    if (RST && bus_if.TX_D_VLD && !bus_if.TX_BUSY) txq.push_back(bus_if.TX_P_DATA);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rx(input logic [7:0] d);
    bus_if.RX_P_DATA = d;
    bus_if.RX_D_VLD  = 1'b1;
    tick();
    bus_if.RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string tag);
    for (int i = 0; i < 200 && txq.size() < n; i++) tick();
    check(tag, 32'(txq.size()), 32'(n));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},   32'(bus_if.ALU_A), 32'h0);
    check({tag, "_b"},   32'(bus_if.ALU_B), 32'h0);
    check({tag, "_fun"}, 32'(bus_if.ALU_FUN), 32'h0);
    check({tag, "_en"},  32'(bus_if.ALU_EN), 32'h0);
    check({tag, "_txd"}, 32'(bus_if.TX_P_DATA), 32'h0);
    check({tag, "_txv"}, 32'(bus_if.TX_D_VLD), 32'h0);
    check({tag, "_err"}, 32'(bus_if.FRAME_ERR), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.RX_P_DATA = 8'h00;
    bus_if.RX_D_VLD  = 1'b0;
    bus_if.TX_BUSY   = 1'b0;
    #2 RST = 1'b0;
    #10;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // CC,05,03,ADD with TX free: exact cycle-by-cycle timing.
    e0 = alu_en_cnt;
    rx(8'hCC); rx(8'h05); rx(8'h03); rx(8'h00);
    check("t1_en_hi", 32'(bus_if.ALU_EN), 32'h1);
    check("t1_a",     32'(bus_if.ALU_A), 32'h05);
    check("t1_b",     32'(bus_if.ALU_B), 32'h03);
    check("t1_fun",   32'(bus_if.ALU_FUN), 32'h0);
    tick();
    check("t1_en_lo", 32'(bus_if.ALU_EN), 32'h0);
    check("t1_txv_wait", 32'(bus_if.TX_D_VLD), 32'h0);
    tick();
    check("t1_txv0", 32'(bus_if.TX_D_VLD), 32'h1);
    check("t1_txd0", 32'(bus_if.TX_P_DATA), 32'h08);
    tick();
    check("t1_gap",  32'(bus_if.TX_D_VLD), 32'h0);
    tick();
    check("t1_txv1", 32'(bus_if.TX_D_VLD), 32'h1);
    check("t1_txd1", 32'(bus_if.TX_P_DATA), 32'h00);
    tick();
    check("t1_txv_end", 32'(bus_if.TX_D_VLD), 32'h0);
    check("t1_idle",  32'(dut.state_q), 32'(ST_IDLE));
    check("t1_nbyte", 32'(txq.size()), 32'd2);
    check("t1_byte0", 32'(txq[0]), 32'h08);
    check("t1_byte1", 32'(txq[1]), 32'h00);
    check("t1_en_cnt", 32'(alu_en_cnt - e0), 32'd1);

    // CC,10,20,MUL with TX busy for 10 cycles.
    txq.delete();
    bus_if.TX_BUSY = 1'b1;
    rx(8'hCC); rx(8'h10); rx(8'h20); rx(8'h02);
    tick(); tick();
    check("t2_txv0", 32'(bus_if.TX_D_VLD), 32'h1);
    check("t2_txd0", 32'(bus_if.TX_P_DATA), 32'h00);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(bus_if.TX_D_VLD === 1'b1 && bus_if.TX_P_DATA === 8'h00)) stable = 1'b0;
    end
    check("t2_stall_stable", 32'(stable), 32'h1);
    check("t2_none_sent", 32'(txq.size()), 32'd0);
    bus_if.TX_BUSY = 1'b0;
    wait_tx(2, "t2_nbyte");
    check("t2_byte0", 32'(txq[0]), 32'h00);
    check("t2_byte1", 32'(txq[1]), 32'h02);
    check("t2_idle",  32'(dut.state_q), 32'(ST_IDLE));

    // DD,SUB reuses A=10, B=20; ALU answers two cycles late.
    txq.delete();
    alu_delay = 2;
    rx(8'hDD); rx(8'h01);
    check("t3_a",   32'(bus_if.ALU_A), 32'h10);
    check("t3_b",   32'(bus_if.ALU_B), 32'h20);
    check("t3_fun", 32'(bus_if.ALU_FUN), 32'h1);
    check("t3_en",  32'(bus_if.ALU_EN), 32'h1);
    tick(); tick();
    check("t3_still_waiting", 32'(bus_if.TX_D_VLD), 32'h0);
    check("t3_wait_state", 32'(dut.state_q), 32'(ST_WAIT_RES));
    wait_tx(2, "t3_nbyte");
    check("t3_byte0", 32'(txq[0]), 32'hF0);
    check("t3_byte1", 32'(txq[1]), 32'hFF);
    alu_delay = 0;

    // Bad command byte, then a normal CC,0F,3C,XOR frame.
    txq.delete();
    e0 = alu_en_cnt;
    rx(8'h5A);
    check("t4_err_hi", 32'(bus_if.FRAME_ERR), 32'h1);
    tick();
    check("t4_err_lo", 32'(bus_if.FRAME_ERR), 32'h0);
    check("t4_idle",   32'(dut.state_q), 32'(ST_IDLE));
    check("t4_no_en",  32'(alu_en_cnt - e0), 32'd0);
    check("t4_no_tx",  32'(bus_if.TX_D_VLD), 32'h0);
    rx(8'hCC); rx(8'h0F); rx(8'h3C); rx(8'h08);
    wait_tx(2, "t4_nbyte");
    check("t4_byte0", 32'(txq[0]), 32'h33);
    check("t4_byte1", 32'(txq[1]), 32'h00);

    // RX byte dropped while SEND is stalled.
    txq.delete();
    bus_if.TX_BUSY = 1'b1;
    rx(8'hCC); rx(8'h03); rx(8'h04); rx(8'h02);
    tick(); tick();
    rx(8'h77);
    check("t5_err_hi", 32'(bus_if.FRAME_ERR), 32'h1);
    check("t5_txv",    32'(bus_if.TX_D_VLD), 32'h1);
    check("t5_txd",    32'(bus_if.TX_P_DATA), 32'h0C);
    check("t5_a_kept", 32'(bus_if.ALU_A), 32'h03);
    tick();
    check("t5_err_lo", 32'(bus_if.FRAME_ERR), 32'h0);
    bus_if.TX_BUSY = 1'b0;
    wait_tx(2, "t5_nbyte");
    check("t5_byte0", 32'(txq[0]), 32'h0C);
    check("t5_byte1", 32'(txq[1]), 32'h00);

    // Reset in GET_B clears operands; DD,ADD then sends 00,00.
    txq.delete();
    rx(8'hCC); rx(8'h07);
    check("t6_a_pre", 32'(bus_if.ALU_A), 32'h07);
    RST = 1'b0;
    #1;
    check_all_zero("t6_rst");
    check("t6_rst_idle", 32'(dut.state_q), 32'(ST_IDLE));
    tick(); tick();
    @(negedge CLK);
    RST = 1'b1;
    tick();
    check("t6_no_tx", 32'(bus_if.TX_D_VLD), 32'h0);
    rx(8'hDD); rx(8'h00);
    check("t6_a", 32'(bus_if.ALU_A), 32'h00);
    check("t6_b", 32'(bus_if.ALU_B), 32'h00);
    wait_tx(2, "t6_nbyte");
    check("t6_byte0", 32'(txq[0]), 32'h00);
    check("t6_byte1", 32'(txq[1]), 32'h00);
    tick();
    check("t6_idle", 32'(dut.state_q), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
